// File: rtl/updown_sweep_ctrl.sv
// updown_sweep_ctrl: sweeps a count between latched bounds for a set number of sweeps, paced by step_en
module updown_sweep_ctrl #(
   parameter int WIDTH = 16,
   parameter int CW = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             step_en,
   input  logic [WIDTH-1:0] begpoint,
   input  logic [WIDTH-1:0] lo_bound,
   input  logic [WIDTH-1:0] hi_bound,
   input  logic [CW-1:0]    sweeps,
   output logic [WIDTH-1:0] counter,
   output logic             dir,
   output logic             busy,
   output logic             done,
   output logic             cfg_err
);
   typedef enum logic [2:0] {IDLE, LOAD, UP, DOWN, DONE} state_t;
   state_t state;
   logic [WIDTH-1:0] beg_r, lo_r, hi_r, nxt;
   logic [CW-1:0] sweeps_r, sweep_cnt, sweep_inc;
   logic cfg_ok, going_down, complete, fin;
   assign cfg_ok = (lo_bound < hi_bound) && (lo_bound <= begpoint) && (begpoint <= hi_bound);
   assign busy = (state == LOAD) || (state == UP) || (state == DOWN);
   // Reversal at hi consumes the step and lands on hi-1; a sweep ends on any downward step landing on lo.
   assign nxt = (state == UP) ? ((counter < hi_r) ? counter + 1'b1 : hi_r - 1'b1)
                              : ((counter > lo_r) ? counter - 1'b1 : counter);
   assign going_down = (state == DOWN) || ((state == UP) && (counter >= hi_r));
   assign complete = going_down && (nxt == lo_r);
   assign sweep_inc = sweep_cnt + 1'b1;
   assign fin = (sweeps_r != '0) && (sweep_inc == sweeps_r);
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         counter   <= '0;
         dir       <= 1'b1;
         done      <= 1'b0;
         cfg_err   <= 1'b0;
         sweep_cnt <= '0;
         beg_r     <= '0;
         lo_r      <= '0;
         hi_r      <= '0;
         sweeps_r  <= '0;
      end else begin
         done    <= 1'b0;
         cfg_err <= 1'b0;
         case (state)
            IDLE, DONE: begin
               state <= IDLE;
               if (start && cfg_ok) begin
                  beg_r     <= begpoint;
                  lo_r      <= lo_bound;
                  hi_r      <= hi_bound;
                  sweeps_r  <= sweeps;
                  sweep_cnt <= '0;
                  state     <= LOAD;
               end else if (start) begin
                  cfg_err <= 1'b1;
               end
            end
            LOAD: begin
               if (stop) begin
                  state <= IDLE;
               end else begin
                  counter <= beg_r;
                  dir     <= 1'b1;
                  state   <= UP;
               end
            end
            UP, DOWN: begin
               if (stop) begin
                  state <= IDLE;
               end else if (step_en) begin
                  counter <= nxt;
                  if (complete) begin
                     sweep_cnt <= sweep_inc;
                     if (fin) begin
                        state <= DONE;
                        done  <= 1'b1;
                     end else begin
                        state <= UP;
                        dir   <= 1'b1;
                     end
                  end else if (going_down) begin
                     state <= DOWN;
                     dir   <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// tb_updown_sweep_ctrl: directed vectors with hand-computed expectations for updown_sweep_ctrl
module tb_updown_sweep_ctrl;
   logic clk = 1'b0;
   logic reset, start, stop, step_en;
   logic [15:0] begpoint, lo_bound, hi_bound, counter;
   logic [7:0] sweeps;
   logic dir, busy, done, cfg_err;
   int checks = 0;
   int errors = 0;
   int idx;
   int seq1 [6] = '{3, 4, 5, 4, 3, 2};
   int seq2 [10] = '{5, 4, 3, 2, 3, 4, 5, 4, 3, 2};
   int dir2 [9] = '{1, 0, 0, 1, 1, 1, 1, 0, 0};

   updown_sweep_ctrl #(.WIDTH(16), .CW(8)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .step_en(step_en),
      .begpoint(begpoint), .lo_bound(lo_bound), .hi_bound(hi_bound), .sweeps(sweeps),
      .counter(counter), .dir(dir), .busy(busy), .done(done), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input int b, input int l, input int h, input int s);
      begpoint = 16'(b);
      lo_bound = 16'(l);
      hi_bound = 16'(h);
      sweeps = 8'(s);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0; step_en = 1'b0;
      cfg(0, 0, 0, 0);
      tick; tick;
      check("rst_counter", 32'(counter), 0);
      check("rst_dir", 32'(dir), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_cfg_err", 32'(cfg_err), 0);
      reset = 1'b0;
      // single sweep, continuous steps
      cfg(3, 2, 5, 1);
      step_en = 1'b1; start = 1'b1;
      tick;
      start = 1'b0;
      check("s1_busy", 32'(busy), 1);
      check("s1_hold", 32'(counter), 0);
      for (int i = 0; i < 6; i++) begin
         tick;
         check($sformatf("s1_cnt%0d", i), 32'(counter), 32'(seq1[i]));
         if (i < 5) check($sformatf("s1_nodone%0d", i), 32'(done), 0);
      end
      check("s1_done", 32'(done), 1);
      check("s1_busy_end", 32'(busy), 0);
      tick;
      check("s1_done_clr", 32'(done), 0);
      // two sweeps starting on the upper bound
      cfg(5, 2, 5, 2);
      start = 1'b1;
      tick;
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick;
         check($sformatf("s2_cnt%0d", i), 32'(counter), 32'(seq2[i]));
         if (i < 9) check($sformatf("s2_dir%0d", i), 32'(dir), 32'(dir2[i]));
      end
      check("s2_done", 32'(done), 1);
      tick;
      check("s2_done_clr", 32'(done), 0);
      // config errors
      cfg(5, 5, 5, 1);
      start = 1'b1;
      tick;
      start = 1'b0;
      check("e1_cfg_err", 32'(cfg_err), 1);
      check("e1_busy", 32'(busy), 0);
      check("e1_counter", 32'(counter), 2);
      tick;
      check("e1_cfg_err_clr", 32'(cfg_err), 0);
      check("e1_busy2", 32'(busy), 0);
      cfg(9, 2, 5, 1);
      start = 1'b1;
      tick;
      start = 1'b0;
      check("e2_cfg_err", 32'(cfg_err), 1);
      check("e2_busy", 32'(busy), 0);
      check("e2_counter", 32'(counter), 2);
      tick;
      check("e2_cfg_err_clr", 32'(cfg_err), 0);
      // paced steps: step_en high every third cycle
      cfg(3, 2, 5, 1);
      step_en = 1'b0; start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      check("p_load", 32'(counter), 3);
      idx = 0;
      for (int k = 0; k < 15; k++) begin
         step_en = (k % 3 == 2);
         tick;
         if (step_en) idx++;
         check($sformatf("p_cnt%0d", k), 32'(counter), 32'(seq1[idx]));
         if (idx == 5) break;
      end
      check("p_done", 32'(done), 1);
      step_en = 1'b1;
      tick;
      check("p_done_clr", 32'(done), 0);
      // stop mid-sweep in DOWN at 4
      cfg(3, 2, 5, 0);
      start = 1'b1;
      tick;
      start = 1'b0;
      tick; tick; tick; tick;
      check("st_pre", 32'(counter), 4);
      check("st_pre_dir", 32'(dir), 0);
      stop = 1'b1;
      tick;
      stop = 1'b0;
      check("st_busy", 32'(busy), 0);
      check("st_counter", 32'(counter), 4);
      check("st_dir", 32'(dir), 0);
      check("st_done", 32'(done), 0);
      tick;
      check("st_hold", 32'(counter), 4);
      cfg(2, 2, 5, 0);
      start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      check("st_reload", 32'(counter), 2);
      check("st_reload_dir", 32'(dir), 1);
      tick; tick; tick;
      check("r_pre", 32'(counter), 5);
      // asynchronous reset between edges
      #2 reset = 1'b1;
      #1;
      check("r_counter", 32'(counter), 0);
      check("r_busy", 32'(busy), 0);
      check("r_dir", 32'(dir), 1);
      start = 1'b1;
      tick;
      check("r_start_ign", 32'(busy), 0);
      start = 1'b0;
      reset = 1'b0;
      tick;
      check("r_idle", 32'(busy), 0);
      check("r_idle_cnt", 32'(counter), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
